score_scan_driver: RTL
======================

Name: score_scan_driver

Overview:
- Downstream consumer of the pong game core's score registers (`score1`, `score2`) and win flags; drives the board's 4-digit common-anode seven-segment display.
- Replaces the inline 2-digit scan with a proper time-multiplexed driver:
  - binary-to-decimal split
  - leading-zero blanking
  - frame-coherent score snapshot
  - blinking of the winner's digits at game over

Parameters:
- `REFRESH_DIV`, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range >= 1.
- `BLINK_TICKS`, 250, digit-slot ticks per blink half-period (250 ms at defaults); legal range >= 1.
- `SCORE_W`, 5, width of each score input.

Ports:
- `clk` input 1: 100 MHz system clock.
- `rst` input 1: asynchronous, active-low reset.
- `score1` input `SCORE_W`: player 1 score, binary, 0..31.
- `score2` input `SCORE_W`: player 2 score, binary, 0..31.
- `winner` input 2: 00 none, 01 P1 won, 10 P2 won, 11 treated as 00.
- `AN` output 4: digit enables, active-low, one-hot-zero.
- `dispout` output 8: segments, active-low, bit7 = dp, bits6..0 = g..a.

Behaviour:
- Reset (`rst`=0, async):
  - `AN`=4'b1111, `dispout`=8'hFF.
  - Divider, slot index, blink counter, snapshots = 0; blink phase = visible.
- Tick generation: divider counts 0..`REFRESH_DIV`-1. Tick pulses one cycle when the divider equals `REFRESH_DIV`-1, then wraps to 0.
- Slot index (2-bit) advances 0→1→2→3→0 on each tick.
- Digit mapping:
  - slot0: `AN`=1110, P2 ones
  - slot1: `AN`=1101, P2 tens
  - slot2: `AN`=1011, P1 ones
  - slot3: `AN`=0111, P1 tens
- Snapshot: `score1`, `score2` and `winner` are captured on the tick that moves slot 3→0. Mid-frame input changes never appear until the next frame (no tearing).
- First frame after reset shows snapshot 0/0/none: `AN` cycles and digits show "0" on ones and blank on tens.
- Latency: `AN`/`dispout` are registered and change exactly 1 clk after the tick; both update in the same cycle.
- Decimal split:
  - tens = snap/10, ones = snap%10; values 0..31 only, tens 0..3.
  - Tens digit with value 0 is blanked (8'hFF); ones digit is always shown.
- Segment codes (dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
- Blink:
  - While snapshot winner is 01 or 10, the blink counter counts ticks 0..`BLINK_TICKS`-1; on wrap, the phase toggles.
  - In the hidden phase the winner's two slots output `dispout`=8'hFF with `AN` still driven. The loser's digits stay steady.
- Blink reset: when snapshot winner is 00 (or 11), the blink counter is held at 0 and the phase is forced visible. A new win therefore always starts visible.
- Simultaneous events: tick coinciding with a blink wrap → the phase toggle applies to the digit emitted on that same tick.
- Reset mid-frame: immediate blanking per reset values; scan restarts at slot 0 after one full `REFRESH_DIV` period.
- Inputs are synchronous to `clk`; no internal synchronizers.

Decomposition:
- Shared package `pong_disp_pkg`:
  - `SEG_0`..`SEG_9`, `SEG_BLANK` (8'hFF) constants
  - `AN_SLOT0`..`AN_SLOT3` constants
  - winner encoding constants `WIN_NONE`/`WIN_P1`/`WIN_P2`
- Sub-module `seg7_decode`: combinational 4-bit digit plus blank flag → 8-bit active-low pattern. Out-of-range digit 10..15 → `SEG_BLANK`.
- The divide-by-10 split stays inline as a small combinational function of the 5-bit snapshot.

Test Plan:
- Reset and idle:
  - Hold `rst`=0 → `AN`=1111, `dispout`=FF.
  - Release with `REFRESH_DIV`=4 → first `AN`=1110 exactly 4 clk after release +1; order 1110,1101,1011,0111 repeats every 16 clk.
- Split and blanking: `score1`=14, `score2`=7 applied before frame start →
  - slot3 `dispout`=F9, slot2=99
  - slot1=FF (blank tens), slot0=F8.
- Snapshot coherence:
  - Change `score2` 7→12 while slot 2 is displayed → remainder of frame still shows 7.
  - Next frame: slot1=F9, slot0=A4.
- Blink: `REFRESH_DIV`=2, `BLINK_TICKS`=8, `winner`=01, `score1`=14 →
  - slots 2/3 alternate visible and FF every 8 ticks.
  - Slots 0/1 steady.
  - `winner`→00 → immediately visible from the next frame.
- Boundary scores:
  - `score1`=31 → slot3=B0, slot2=F9.
  - `score1`=10 → F9/C0.
  - `score1`=0 → FF/C0.
  - `winner`=11 → no blinking.
- Async reset mid-scan: assert `rst` between clock edges during slot 2 → outputs go FF/1111 without a clock edge; scan resumes from slot 0.

Source files
------------

// File: rtl/pong_disp_pkg.sv
// Shared constants for the pong score display path.
// Holds the active-low seven-segment patterns (bit7 = dp, bits6..0 = g..a),
// the active-low digit-enable patterns of the four scan slots, the winner
// encoding produced by the game core and the slot-index type of the scan.
package pong_disp_pkg;

    // Segment patterns, active-low, decimal point off
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Digit enables, active-low, one slot at a time
    localparam logic [3:0] AN_SLOT0  = 4'b1110;
    localparam logic [3:0] AN_SLOT1  = 4'b1101;
    localparam logic [3:0] AN_SLOT2  = 4'b1011;
    localparam logic [3:0] AN_SLOT3  = 4'b0111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Winner encoding from the game core; 2'b11 is treated like WIN_NONE
    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_P1    = 2'b01;
    localparam logic [1:0] WIN_P2    = 2'b10;

    // Scan slots in display order
    typedef enum logic [1:0] {
        SLOT_P2_ONES = 2'd0,
        SLOT_P2_TENS = 2'd1,
        SLOT_P1_ONES = 2'd2,
        SLOT_P1_TENS = 2'd3
    } slot_e;

    // True only for a real game-over; the unused code 2'b11 never blinks
    function automatic logic win_active(input logic [1:0] w);
        return (w == WIN_P1) || (w == WIN_P2);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to seven-segment decoder.
// Ports:
//   digit - 4-bit decimal digit; codes 10..15 decode to a blank pattern
//   blank - forces the blank pattern regardless of digit
//   seg   - active-low pattern, bit7 = dp (always off), bits6..0 = g..a
module seg7_decode
    import pong_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [7:0] seg
);

    // Digit lookup with blank override
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/score_scan_driver.sv
// Time-multiplexed driver for the 4-digit common-anode score display.
// Every REFRESH_DIV clocks one digit slot is emitted: P2 ones, P2 tens,
// P1 ones, P1 tens. Scores and winner are snapshotted once per frame so a
// frame never mixes old and new values. Tens digits of zero are blanked and
// the winner's digits blink with a half-period of BLINK_TICKS slots.
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-low reset
//   score1  - player 1 score, binary 0..31
//   score2  - player 2 score, binary 0..31
//   winner  - 00 none, 01 P1 won, 10 P2 won, 11 treated as none
//   AN      - registered digit enables, active-low, one-hot-zero
//   dispout - registered segments, active-low, bit7 = dp, bits6..0 = g..a
module score_scan_driver
    import pong_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_TICKS = 250,
    parameter int SCORE_W     = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score1,
    input  logic [SCORE_W-1:0] score2,
    input  logic [1:0]         winner,
    output logic [3:0]         AN,
    output logic [7:0]         dispout
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

    // Binary score to {tens, ones}; valid for 0..39, tens never exceeds 3
    function automatic logic [7:0] dec_split(input logic [SCORE_W-1:0] v);
        logic [3:0]         tens;
        logic [SCORE_W-1:0] rem;
        if (v >= SCORE_W'(30)) begin
            tens = 4'd3;
            rem  = v - SCORE_W'(30);
        end else if (v >= SCORE_W'(20)) begin
            tens = 4'd2;
            rem  = v - SCORE_W'(20);
        end else if (v >= SCORE_W'(10)) begin
            tens = 4'd1;
            rem  = v - SCORE_W'(10);
        end else begin
            tens = 4'd0;
            rem  = v;
        end
        return {tens, 4'(rem)};
    endfunction

    logic [DIV_W-1:0]   div_r;
    slot_e              slot_r;
    logic [SCORE_W-1:0] snap1_r;
    logic [SCORE_W-1:0] snap2_r;
    logic [1:0]         snap_win_r;
    logic [BLK_W-1:0]   blink_cnt_r;
    logic               hidden_r;
    logic [3:0]         an_r;
    logic [7:0]         seg_r;

    logic               tick_s;
    logic               win_active_s;
    logic               hidden_next_s;
    logic [7:0]         split1_s;
    logic [7:0]         split2_s;
    logic [3:0]         digit_s;
    logic               is_tens_s;
    logic               p1_slot_s;
    logic [3:0]         an_s;
    logic               own_s;
    logic               blank_s;
    logic [7:0]         seg_s;

    assign tick_s       = (div_r == DIV_LAST);
    assign win_active_s = win_active(snap_win_r);
    assign AN           = an_r;
    assign dispout      = seg_r;

    // Blink phase that applies to the digit emitted on this tick, so a wrap
    // coinciding with a tick already affects that digit
    always_comb begin
        hidden_next_s = 1'b0;
        if (!win_active_s) begin
            hidden_next_s = 1'b0;
        end else if (tick_s && (blink_cnt_r == BLK_LAST)) begin
            hidden_next_s = ~hidden_r;
        end else begin
            hidden_next_s = hidden_r;
        end
    end

    // Select digit, position and enable for the slot being emitted
    always_comb begin
        split1_s  = dec_split(snap1_r);
        split2_s  = dec_split(snap2_r);
        digit_s   = 4'd0;
        is_tens_s = 1'b0;
        p1_slot_s = 1'b0;
        an_s      = AN_OFF;
        case (slot_r)
            SLOT_P2_ONES: begin
                digit_s = split2_s[3:0];
                an_s    = AN_SLOT0;
            end
            SLOT_P2_TENS: begin
                digit_s   = split2_s[7:4];
                is_tens_s = 1'b1;
                an_s      = AN_SLOT1;
            end
            SLOT_P1_ONES: begin
                digit_s   = split1_s[3:0];
                p1_slot_s = 1'b1;
                an_s      = AN_SLOT2;
            end
            SLOT_P1_TENS: begin
                digit_s   = split1_s[7:4];
                is_tens_s = 1'b1;
                p1_slot_s = 1'b1;
                an_s      = AN_SLOT3;
            end
            default: begin
                digit_s = 4'd0;
                an_s    = AN_OFF;
            end
        endcase
    end

    // Blank a zero tens digit, or the winner's digits in the hidden phase
    always_comb begin
        own_s = ((snap_win_r == WIN_P1) && p1_slot_s) ||
                ((snap_win_r == WIN_P2) && !p1_slot_s);
        if (is_tens_s && (digit_s == 4'd0)) begin
            blank_s = 1'b1;
        end else if (hidden_next_s && own_s) begin
            blank_s = 1'b1;
        end else begin
            blank_s = 1'b0;
        end
    end

    seg7_decode u_seg7_decode (
        .digit (digit_s),
        .blank (blank_s),
        .seg   (seg_s)
    );

    // Slot-rate divider: wraps to zero on the tick cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_r <= '0;
        end else if (tick_s) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Scan sequencer: emit the current slot, advance, snapshot at frame end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_r     <= SLOT_P2_ONES;
            snap1_r    <= '0;
            snap2_r    <= '0;
            snap_win_r <= WIN_NONE;
            an_r       <= AN_OFF;
            seg_r      <= SEG_BLANK;
        end else if (tick_s) begin
            an_r   <= an_s;
            seg_r  <= seg_s;
            slot_r <= slot_e'(slot_r + 2'd1);
            // The slot-3 tick closes the frame; the next frame uses fresh values
            if (slot_r == SLOT_P1_TENS) begin
                snap1_r    <= score1;
                snap2_r    <= score2;
                snap_win_r <= winner;
            end
        end
    end

    // Blink timer: counts ticks only while the snapshot holds a winner
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_r <= '0;
            hidden_r    <= 1'b0;
        end else if (!win_active_s) begin
            blink_cnt_r <= '0;
            hidden_r    <= 1'b0;
        end else if (tick_s) begin
            hidden_r <= hidden_next_s;
            if (blink_cnt_r == BLK_LAST) begin
                blink_cnt_r <= '0;
            end else begin
                blink_cnt_r <= blink_cnt_r + BLK_W'(1);
            end
        end
    end

endmodule
